// File: rtl/mod10_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mod10_step_sequencer
// Description : Two-requester controller for a shared modulo-10 step counter.
//               Round-robin grant, then drives the counter step code (w1,w0)
//               each cycle until the counter equals the latched target digit.
//               Optional step timeout enabled by defining MOD10_SEQ_TIMEOUT_EN
//               (adds parameter MAX_STEPS).
// Revision    : 1.0 - initial release
// ============================================================================
module mod10_step_sequencer
`ifdef MOD10_SEQ_TIMEOUT_EN
#(
  parameter int MAX_STEPS = 12
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] tgt0,
  input  logic [3:0] tgt1,
  input  logic       dir0,
  input  logic       dir1,
  input  logic [3:0] cnt_state,
  output logic       ack0,
  output logic       ack1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic       cnt_run,
  output logic       w1,
  output logic       w0
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] W_HOLD = 2'b00;
  localparam logic [1:0] W_INC1 = 2'b01;
  localparam logic [1:0] W_INC2 = 2'b10;
  localparam logic [1:0] W_DEC1 = 2'b11;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;     // 0 = req0, 1 = req1
  logic [3:0] tgt_q, tgt_d;
  logic       dir_q, dir_d;
  logic       rr_q, rr_d;           // requester served last
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       err_q, err_d;

  logic       grant1;
  logic [3:0] sel_tgt;
  logic [4:0] up_raw, up_dist;
  logic [4:0] dn_raw, dn_dist;
  logic [1:0] step_code;
  logic       match;
  logic [1:0] w_code;

`ifdef MOD10_SEQ_TIMEOUT_EN
  localparam int SCW = $clog2(MAX_STEPS + 1);
  logic [SCW-1:0] step_cnt_q, step_cnt_d;
`endif

  // Distance to target in each direction and the resulting raw step code.
  // Adding 10 before subtracting keeps the 5-bit intermediate non-negative,
  // which makes the 9->0 / 0->9 wrap fall out of a single conditional -10.
  always_comb begin
    up_raw  = {1'b0, tgt_q} + 5'd10 - {1'b0, cnt_state};
    up_dist = (up_raw >= 5'd10) ? (up_raw - 5'd10) : up_raw;
    dn_raw  = {1'b0, cnt_state} + 5'd10 - {1'b0, tgt_q};
    dn_dist = (dn_raw >= 5'd10) ? (dn_raw - 5'd10) : dn_raw;
    if (dir_q) begin
      match     = (dn_dist == 5'd0);
      step_code = match ? W_HOLD : W_DEC1;
    end else begin
      match = (up_dist == 5'd0);
      if (up_dist >= 5'd2) begin
        step_code = W_INC2;
      end else if (up_dist == 5'd1) begin
        step_code = W_INC1;
      end else begin
        step_code = W_HOLD;
      end
    end
  end

  // Round-robin choice: a lone request wins; on a tie the one not served last.
  always_comb begin
    grant1  = req1 & (~req0 | ~rr_q);
    sel_tgt = grant1 ? tgt1 : tgt0;
  end

  // Sequencer next-state, handshake pulses and step-code selection.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    rr_d    = rr_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err_d   = 1'b0;
    w_code  = W_HOLD;
`ifdef MOD10_SEQ_TIMEOUT_EN
    step_cnt_d = step_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          owner_d = grant1;
          tgt_d   = sel_tgt;
          dir_d   = grant1 ? dir1 : dir0;
          ack0_d  = ~grant1;
          ack1_d  = grant1;
`ifdef MOD10_SEQ_TIMEOUT_EN
          step_cnt_d = '0;
`endif
          if (sel_tgt > 4'd9) begin
            // Unreachable digit: reject without ever touching the counter.
            state_d = S_DONE;
            err_d   = 1'b1;
            done0_d = ~grant1;
            done1_d = grant1;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        if (match) begin
          state_d = S_DONE;
          done0_d = ~owner_q;
          done1_d = owner_q;
`ifdef MOD10_SEQ_TIMEOUT_EN
        end else if (step_cnt_q >= SCW'(MAX_STEPS)) begin
          // Counter never arrived: stop stepping and report an abort.
          state_d = S_DONE;
          err_d   = 1'b1;
          done0_d = ~owner_q;
          done1_d = owner_q;
        end else begin
          w_code     = step_code;
          step_cnt_d = step_cnt_q + SCW'(1);
`else
        end else begin
          w_code = step_code;
`endif
        end
      end
      S_DONE: begin
        rr_d    = owner_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and handshake registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      tgt_q   <= 4'd0;
      dir_q   <= 1'b0;
      rr_q    <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      rr_q    <= rr_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err_q   <= err_d;
    end
  end

`ifdef MOD10_SEQ_TIMEOUT_EN
  // Count of cycles spent actively stepping for the current request.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
    end
  end
`endif

  // Outputs are forced to their idle values while reset is asserted so an
  // aborted request never leaks a step code or a done pulse.
  assign cnt_run  = ~rst;
  assign {w1, w0} = rst ? W_HOLD : w_code;
  assign ack0     = ack0_q & ~rst;
  assign ack1     = ack1_q & ~rst;
  assign done0    = done0_q & ~rst;
  assign done1    = done1_q & ~rst;
  assign err      = err_q & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_mod10_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod10_step_sequencer
// Description : Self-checking bench for mod10_step_sequencer with a behavioural
//               modulo-10 step counter attached to the sequencer outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod10_step_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] tgt0 = 4'd0, tgt1 = 4'd0;
  logic       dir0 = 1'b0, dir1 = 1'b0;
  logic [3:0] cnt_state = 4'd5;
  logic       freeze = 1'b0;
  logic       ack0, ack1, done0, done1, err, cnt_run, w1, w0;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  mod10_step_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .tgt0      (tgt0),
    .tgt1      (tgt1),
    .dir0      (dir0),
    .dir1      (dir1),
    .cnt_state (cnt_state),
    .ack0      (ack0),
    .ack1      (ack1),
    .done0     (done0),
    .done1     (done1),
    .err       (err),
    .cnt_run   (cnt_run),
    .w1        (w1),
    .w0        (w0)
  );

  // Shared modulo-10 step counter; freeze models a stuck counter.
  always @(posedge clk) begin
    if (!cnt_run) begin
      cnt_state <= 4'd0;
    end else if (!freeze) begin
      case ({w1, w0})
        2'b01:   cnt_state <= 4'((int'(cnt_state) + 1) % 10);
        2'b10:   cnt_state <= 4'((int'(cnt_state) + 2) % 10);
        2'b11:   cnt_state <= 4'((int'(cnt_state) + 9) % 10);
        default: cnt_state <= cnt_state;
      endcase
    end
  end

  // Expected step codes (2 = +2, 1 = +1, 3 = -1, final 0 = arrived).
  function automatic void build_seq(input int start, input int tgt, input bit dir);
    int c;
    c = start;
    exp_q.delete();
    while (c != tgt) begin
      if (dir) begin
        exp_q.push_back(3);
        c = (c + 9) % 10;
      end else if (((tgt - c + 10) % 10) >= 2) begin
        exp_q.push_back(2);
        c = (c + 2) % 10;
      end else begin
        exp_q.push_back(1);
        c = (c + 1) % 10;
      end
    end
    exp_q.push_back(0);
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Issue one request (entered and left in an IDLE cycle, #1 after the edge).
  task automatic serve(input int who, input int tgt, input bit dir, input bit keep, input string nm);
    int start;
    logic [1:0] one;
    one = (who == 0) ? 2'b01 : 2'b10;
    if (who == 0) begin
      req0 = 1'b1; tgt0 = 4'(tgt); dir0 = dir;
    end else begin
      req1 = 1'b1; tgt1 = 4'(tgt); dir1 = dir;
    end
    start = int'(cnt_state);
    if (tgt <= 9) build_seq(start, tgt, dir);
    @(posedge clk); #1;
    n_tests++;
    if ({ack1, ack0} !== one) begin
      n_fail++;
      $display("FAIL %s ack: got %b expected %b", nm, {ack1, ack0}, one);
    end
    if (tgt > 9) begin
      n_tests++;
      if ({done1, done0} !== one || err !== 1'b1 || {w1, w0} !== 2'b00 || cnt_state !== 4'(start)) begin
        n_fail++;
        $display("FAIL %s reject: done=%b err=%b w=%b cnt=%0d expected done=%b err=1 w=00 cnt=%0d",
                 nm, {done1, done0}, err, {w1, w0}, cnt_state, one, start);
      end
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) begin
          @(posedge clk); #1;
        end
        n_tests++;
        if ({w1, w0} !== 2'(exp_q[i]) || {done1, done0} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s step %0d: w=%b done=%b expected w=%b done=00",
                   nm, i, {w1, w0}, {done1, done0}, 2'(exp_q[i]));
        end
      end
      @(posedge clk); #1;
      n_tests++;
      if ({done1, done0} !== one || err !== 1'b0 || {w1, w0} !== 2'b00 || cnt_state !== 4'(tgt)) begin
        n_fail++;
        $display("FAIL %s done: done=%b err=%b w=%b cnt=%0d expected done=%b err=0 w=00 cnt=%0d",
                 nm, {done1, done0}, err, {w1, w0}, cnt_state, one, tgt);
      end
    end
    if (!keep) begin
      if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    end
    @(posedge clk); #1;
    n_tests++;
    if ({ack1, ack0, done1, done0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s idle: ack=%b done=%b expected 00/00", nm, {ack1, ack0}, {done1, done0});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({w1, w0, ack1, ack0, done1, done0, err, cnt_run} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: w=%b ack=%b done=%b err=%b run=%b expected all 0",
               {w1, w0}, {ack1, ack0}, {done1, done0}, err, cnt_run);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (cnt_state !== 4'd0 || cnt_run !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: cnt=%0d run=%b expected cnt=0 run=1", cnt_state, cnt_run);
    end
  endtask

  task automatic test_up_down_wrap();
    serve(0, 7, 1'b0, 1'b0, "up_0to7");
    serve(1, 5, 1'b1, 1'b0, "down_7to5");
    serve(0, 8, 1'b0, 1'b0, "up_5to8");
    serve(1, 1, 1'b0, 1'b0, "wrap_8to1");
    serve(0, 8, 1'b1, 1'b0, "wrap_down_1to8");
    serve(1, 8, 1'b0, 1'b0, "already_equal");
  endtask

  task automatic test_tie();
    apply_reset();
    req1 = 1'b1; tgt1 = 4'd4; dir1 = 1'b0;
    serve(0, 2, 1'b0, 1'b1, "tie_first_req0");
    tgt0 = 4'd9;
    serve(1, 6, 1'b1, 1'b0, "tie_then_req1");
    serve(0, 9, 1'b0, 1'b0, "tie_back_req0");
  endtask

  task automatic test_bad_target();
    serve(0, 12, 1'b0, 1'b0, "bad_tgt12");
    serve(1, 10, 1'b1, 1'b0, "bad_tgt10");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req0 = 1'b1; tgt0 = 4'd9; dir0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    n_tests++;
    if ({w1, w0} !== 2'b00 || cnt_run !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_comb: w=%b run=%b expected w=00 run=0", {w1, w0}, cnt_run);
    end
    @(posedge clk); #1;
    n_tests++;
    if (cnt_state !== 4'd0 || {done1, done0, ack1, ack0, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: cnt=%0d done=%b ack=%b err=%b expected 0",
               cnt_state, {done1, done0}, {ack1, ack0}, err);
    end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      n_tests++;
      if ({done1, done0, w1, w0} !== 4'b0 || cnt_state !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_mid_after: done=%b w=%b cnt=%0d expected 00/00/0",
                 {done1, done0}, {w1, w0}, cnt_state);
      end
    end
  endtask

  task automatic test_stuck_counter();
    serve(0, 3, 1'b0, 1'b0, "to_3");
    freeze = 1'b1;
    req0 = 1'b1; tgt0 = 4'd6; dir0 = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({ack1, ack0} !== 2'b01) begin
      n_fail++;
      $display("FAIL stuck_ack: got %b expected 01", {ack1, ack0});
    end
`ifdef MOD10_SEQ_TIMEOUT_EN
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      n_tests++;
      if ({w1, w0} !== 2'b10 || {done1, done0} !== 2'b00) begin
        n_fail++;
        $display("FAIL stuck_step %0d: w=%b done=%b expected w=10 done=00", i, {w1, w0}, {done1, done0});
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if ({w1, w0} !== 2'b00 || {done1, done0} !== 2'b00) begin
      n_fail++;
      $display("FAIL stuck_abort: w=%b done=%b expected w=00 done=00", {w1, w0}, {done1, done0});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({done1, done0} !== 2'b01 || err !== 1'b1 || cnt_state !== 4'd3) begin
      n_fail++;
      $display("FAIL stuck_done: done=%b err=%b cnt=%0d expected done=01 err=1 cnt=3",
               {done1, done0}, err, cnt_state);
    end
    freeze = 1'b0;
`else
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      n_tests++;
      if ({w1, w0} !== 2'b10 || {done1, done0} !== 2'b00) begin
        n_fail++;
        $display("FAIL stall_step %0d: w=%b done=%b expected w=10 done=00", i, {w1, w0}, {done1, done0});
      end
    end
    freeze = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({w1, w0} !== 2'b01 || cnt_state !== 4'd5) begin
      n_fail++;
      $display("FAIL stall_resume: w=%b cnt=%0d expected w=01 cnt=5", {w1, w0}, cnt_state);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++;
    if ({done1, done0} !== 2'b01 || err !== 1'b0 || cnt_state !== 4'd6) begin
      n_fail++;
      $display("FAIL stall_done: done=%b err=%b cnt=%0d expected done=01 err=0 cnt=6",
               {done1, done0}, err, cnt_state);
    end
`endif
    req0 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      serve(int'($urandom_range(0, 1)), int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), 1'b0, "rand");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_up_down_wrap();
    test_bad_target();
    test_tie();
    test_stuck_counter();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
